// File: rtl/fft_twiddle_rotator.sv
`default_nettype none
// ============================================================================
// Module   : fft_twiddle_rotator
// Purpose  : Inter-stage twiddle multiplier for a pipelined FFT. Generates the
//            twiddle ROM addresses from the natural-order sample index. It then
//            multiplies each complex sample by W_N^e, where e = (r*c) mod N.
//            Results are rounded half-up from Q2.16 back to DW bits.
// Options  : TWR_SAT_EN - saturate results and pulse ovf (default: wrap)
// Revision : 1.0 - initial release
// ============================================================================
module fft_twiddle_rotator #(
    parameter int DW      = 16,
    parameter int TW      = 18,
    parameter int N       = 16,
    parameter int R       = 4,
    parameter int AW      = 9,
    parameter int ROM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_sop,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    output logic [AW-1:0] rom_addra,
    output logic [AW-1:0] rom_addrb,
    input  logic [TW-1:0] rom_doa,
    input  logic [TW-1:0] rom_dob,
    output logic          out_valid,
    output logic          out_sop,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic          ovf
);

    localparam int c_LOGN  = $clog2(N);
    localparam int c_LOGB  = $clog2(N / R);
    localparam int c_SHIFT = 8 - c_LOGN;
    localparam int c_PW    = DW + TW;
    localparam int c_FW    = DW + TW + 1;
    localparam logic [c_LOGN-1:0] c_RMASK = c_LOGN'(N / R - 1);

    // ------------------------------------------------------------------
    // Exponent generation: r_cnt/r_e/r_step describe the *next* sample.
    // ------------------------------------------------------------------
    logic [c_LOGN-1:0] r_cnt, r_e, r_step;
    logic [c_LOGN-1:0] w_s_cur, w_e_cur, w_step_cur;
    logic [c_LOGN-1:0] w_s_nxt, w_c_nxt, w_e_nxt, w_step_nxt;
    logic              w_blk_start;
    logic [AW-1:0]     w_addr, r_addra, r_addrb;

    // Current-sample index/exponent (sop restarts the frame) and next-sample update
    always_comb begin
        w_s_cur     = in_sop ? '0 : r_cnt;
        w_e_cur     = in_sop ? '0 : r_e;
        w_step_cur  = in_sop ? '0 : r_step;
        w_s_nxt     = w_s_cur + c_LOGN'(1);
        w_blk_start = ((w_s_nxt & c_RMASK) == '0);
        w_c_nxt     = w_s_nxt >> c_LOGB;
        w_e_nxt     = w_blk_start ? '0 : (w_e_cur + w_step_cur);
        w_step_nxt  = w_blk_start ? w_c_nxt : w_step_cur;
        w_addr      = AW'(w_e_cur) << c_SHIFT;
    end

    // Stage A: counters advance and ROM addresses register only on valid samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_e     <= '0;
            r_step  <= '0;
            r_addra <= '0;
            r_addrb <= '0;
        end else if (in_valid) begin
            r_cnt   <= w_s_nxt;
            r_e     <= w_e_nxt;
            r_step  <= w_step_nxt;
            r_addra <= w_addr;
            r_addrb <= w_addr + AW'(256);
        end
    end

    // ------------------------------------------------------------------
    // Data delay line: index 0 is stage A, index ROM_LAT meets ROM data.
    // ------------------------------------------------------------------
    logic signed [DW-1:0] r_d_re  [0:ROM_LAT];
    logic signed [DW-1:0] r_d_im  [0:ROM_LAT];
    logic                 r_d_vld [0:ROM_LAT];
    logic                 r_d_sop [0:ROM_LAT];

    // Capture the sample alongside its address, then age it through the ROM latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= ROM_LAT; i++) begin
                r_d_re[i]  <= '0;
                r_d_im[i]  <= '0;
                r_d_vld[i] <= 1'b0;
                r_d_sop[i] <= 1'b0;
            end
        end else begin
            r_d_re[0]  <= $signed(in_re);
            r_d_im[0]  <= $signed(in_im);
            r_d_vld[0] <= in_valid;
            r_d_sop[0] <= in_valid & in_sop;
            for (int i = 1; i <= ROM_LAT; i++) begin
                r_d_re[i]  <= r_d_re[i-1];
                r_d_im[i]  <= r_d_im[i-1];
                r_d_vld[i] <= r_d_vld[i-1];
                r_d_sop[i] <= r_d_sop[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage M: four real products, operands sign-extended to full width
    // ------------------------------------------------------------------
    logic signed [c_PW-1:0] w_a, w_b, w_c, w_d;
    logic signed [c_PW-1:0] r_m_ac, r_m_bd, r_m_ad, r_m_bc;
    logic                   r_m_vld, r_m_sop;

    assign w_a = c_PW'(r_d_re[ROM_LAT]);
    assign w_b = c_PW'(r_d_im[ROM_LAT]);
    assign w_c = c_PW'($signed(rom_doa));
    assign w_d = c_PW'($signed(rom_dob));

    // Register the partial products together with their qualifiers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_ac  <= '0;
            r_m_bd  <= '0;
            r_m_ad  <= '0;
            r_m_bc  <= '0;
            r_m_vld <= 1'b0;
            r_m_sop <= 1'b0;
        end else begin
            r_m_ac  <= w_a * w_c;
            r_m_bd  <= w_b * w_d;
            r_m_ad  <= w_a * w_d;
            r_m_bc  <= w_b * w_c;
            r_m_vld <= r_d_vld[ROM_LAT];
            r_m_sop <= r_d_sop[ROM_LAT];
        end
    end

    // ------------------------------------------------------------------
    // Stage S: combine, round half-up, reduce to DW bits
    // ------------------------------------------------------------------
    logic signed [c_FW-1:0] w_re_full, w_im_full, w_re_rnd, w_im_rnd;
    logic [DW-1:0]          w_re_q, w_im_q;
    logic                   w_ovf;

    assign w_re_full = c_FW'(r_m_ac) - c_FW'(r_m_bd);
    assign w_im_full = c_FW'(r_m_ad) + c_FW'(r_m_bc);
    assign w_re_rnd  = (w_re_full + c_FW'(32768)) >>> 16;
    assign w_im_rnd  = (w_im_full + c_FW'(32768)) >>> 16;

`ifdef TWR_SAT_EN
    localparam logic signed [c_FW-1:0] c_MAX = (c_FW'(1) <<< (DW - 1)) - c_FW'(1);
    localparam logic signed [c_FW-1:0] c_MIN = -c_MAX - c_FW'(1);
    logic w_re_ovf, w_im_ovf;

    // Clamp each component to the DW-bit range and flag any clamping
    always_comb begin
        w_re_ovf = (w_re_rnd > c_MAX) || (w_re_rnd < c_MIN);
        w_im_ovf = (w_im_rnd > c_MAX) || (w_im_rnd < c_MIN);
        w_re_q   = w_re_ovf ? (w_re_rnd[c_FW-1] ? c_MIN[DW-1:0] : c_MAX[DW-1:0])
                            : w_re_rnd[DW-1:0];
        w_im_q   = w_im_ovf ? (w_im_rnd[c_FW-1] ? c_MIN[DW-1:0] : c_MAX[DW-1:0])
                            : w_im_rnd[DW-1:0];
        w_ovf    = w_re_ovf | w_im_ovf;
    end
`else
    logic w_unused_bits;

    // Two's-complement wrap: keep the low DW bits, overflow never reported
    always_comb begin
        w_re_q        = w_re_rnd[DW-1:0];
        w_im_q        = w_im_rnd[DW-1:0];
        w_ovf         = 1'b0;
        w_unused_bits = ^{w_re_rnd[c_FW-1:DW], w_im_rnd[c_FW-1:DW]};
    end
`endif

    logic          r_out_valid, r_out_sop, r_ovf;
    logic [DW-1:0] r_out_re, r_out_im;

    // Output register: data holds between valid samples, ovf is a per-sample pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
        end else begin
            r_out_valid <= r_m_vld;
            r_out_sop   <= r_m_sop;
            r_ovf       <= r_m_vld & w_ovf;
            if (r_m_vld) begin
                r_out_re <= w_re_q;
                r_out_im <= w_im_q;
            end
        end
    end

    assign rom_addra = r_addra;
    assign rom_addrb = r_addrb;
    assign out_valid = r_out_valid;
    assign out_sop   = r_out_sop;
    assign out_re    = r_out_re;
    assign out_im    = r_out_im;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fft_twiddle_rotator.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_twiddle_rotator
// Purpose  : Directed self-checking bench for fft_twiddle_rotator (N=16, R=4).
//            A one-cycle-latency twiddle ROM model sits on the address ports.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_twiddle_rotator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_sop;
    logic [15:0] in_re, in_im;
    logic [8:0]  rom_addra, rom_addrb;
    logic [17:0] rom_doa, rom_dob;
    logic        out_valid, out_sop, ovf;
    logic [15:0] out_re, out_im;

    logic signed [17:0] rom [0:511];

    int ntests = 0;
    int nfail  = 0;

    fft_twiddle_rotator #(
        .DW(16), .TW(18), .N(16), .R(4), .AW(9), .ROM_LAT(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
        .in_re     (in_re),
        .in_im     (in_im),
        .rom_addra (rom_addra),
        .rom_addrb (rom_addrb),
        .rom_doa   (rom_doa),
        .rom_dob   (rom_dob),
        .out_valid (out_valid),
        .out_sop   (out_sop),
        .out_re    (out_re),
        .out_im    (out_im),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Twiddle ROM: one cycle from address to data
    always @(posedge clk) begin
        rom_doa <= rom[rom_addra];
        rom_dob <= rom[rom_addrb];
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [39:0] obs,
                       input logic signed [39:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference exponent straight from the definition e = (r*c) mod N
    function automatic int ref_e(input int s);
        return ((s % 4) * (s / 4)) % 16;
    endfunction

    int ms, vc, e, exp_re, exp_ov;
    int vp[24] = '{1,1,0,1,1,1,0,0,1,1,1,1,0,1,1,0,1,0,1,1,0,0,0,0};
    int vh[24];

    initial begin
        // ROM: identity by default, plus the angles the directed vectors use
        for (int i = 0; i < 256; i++) rom[i] = 18'sd65536;
        for (int i = 256; i < 512; i++) rom[i] = 18'sd0;
        rom[64]  = 18'sd0;      rom[320] = -18'sd65536;   // e=4: -j
        rom[32]  = 18'sd46340;  rom[288] = -18'sd46340;   // e=2: pi/4
        rom_doa = '0; rom_dob = '0;

        rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_re = '0; in_im = '0;
        cyc(); cyc(); cyc();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sop",   out_sop,   0);
        chk("rst_out_re",    $signed(out_re), 0);
        chk("rst_out_im",    $signed(out_im), 0);
        chk("rst_ovf",       ovf,       0);
        chk("rst_addra",     rom_addra, 0);
        chk("rst_addrb",     rom_addrb, 0);
        rst_n = 1'b1;
        cyc();

        // ---- Single sop sample through the identity twiddle ----
        in_valid = 1'b1; in_sop = 1'b1; in_re = 16'sd1000; in_im = -16'sd2000;
        cyc();
        in_valid = 1'b0; in_sop = 1'b0;
        chk("t1_addra", rom_addra, 0);
        chk("t1_addrb", rom_addrb, 256);
        cyc(); cyc();
        chk("t1_lat3_valid", out_valid, 0);
        cyc();
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_sop",   out_sop,   1);
        chk("t1_out_re",    $signed(out_re), 1000);
        chk("t1_out_im",    $signed(out_im), -2000);
        chk("t1_ovf",       ovf,       0);
        cyc(); cyc();

        // ---- Full frame: address sequence, plus s=10 rotated by -j ----
        for (int s = 0; s < 16; s++) begin
            in_valid = 1'b1; in_sop = (s == 0); in_re = 16'sd16384; in_im = 16'sd0;
            cyc();
            chk($sformatf("frame_addra_s%0d", s), rom_addra, ref_e(s) * 16);
            chk($sformatf("frame_addrb_s%0d", s), rom_addrb, 256 + ref_e(s) * 16);
            if (s == 3) begin
                chk("frame_s0_sop", out_sop, 1);
                chk("frame_s0_re",  $signed(out_re), 16384);
            end
            if (s == 13) begin
                chk("frame_s10_re", $signed(out_re), 0);
                chk("frame_s10_im", $signed(out_im), -16384);
                chk("frame_s10_sop", out_sop, 0);
            end
        end
        in_valid = 1'b0; in_sop = 1'b0;
        cyc(); cyc(); cyc(); cyc();

        // ---- s=6 (e=2) with full-scale negative input: overflow case ----
        for (int s = 0; s < 7; s++) begin
            in_valid = 1'b1; in_sop = (s == 0);
            in_re = (s == 6) ? -16'sd32768 : 16'sd0;
            in_im = (s == 6) ? -16'sd32768 : 16'sd0;
            cyc();
        end
        chk("sat_addra", rom_addra, 32);
        in_valid = 1'b0; in_sop = 1'b0;
        cyc(); cyc(); cyc();
`ifdef TWR_SAT_EN
        exp_re = -32768; exp_ov = 1;
`else
        exp_re = 19196;  exp_ov = 0;
`endif
        chk("sat_out_valid", out_valid, 1);
        chk("sat_out_re",    $signed(out_re), exp_re);
        chk("sat_out_im",    $signed(out_im), 0);
        chk("sat_ovf",       ovf, exp_ov);
        cyc();
        chk("sat_after_valid", out_valid, 0);
        chk("sat_after_ovf",   ovf, 0);
        chk("sat_hold_re",     $signed(out_re), exp_re);
        cyc(); cyc(); cyc();

        // ---- Gapped input, sop re-asserted on the 8th valid sample ----
        ms = 0; vc = 0;
        for (int t = 0; t < 24; t++) begin
            vh[t] = vp[t];
            in_valid = (vp[t] != 0);
            in_sop   = 1'b0;
            if (vp[t] != 0) begin
                in_sop = (vc == 0) || (vc == 7);
                if (in_sop) ms = 0;
                in_re = 16'(100 * (t + 1));
                in_im = 16'(-50 * (t + 1));
            end
            cyc();
            if (vp[t] != 0) begin
                chk($sformatf("gap_addra_t%0d", t), rom_addra, ref_e(ms) * 16);
                ms = (ms + 1) % 16;
                vc++;
            end
            chk($sformatf("gap_valid_t%0d", t), out_valid, (t >= 3) ? vh[t-3] : 0);
        end
        in_valid = 1'b0; in_sop = 1'b0;
        cyc(); cyc();

        // ---- Reset mid-frame with samples in flight ----
        for (int s = 0; s < 7; s++) begin
            in_valid = 1'b1; in_sop = (s == 0); in_re = 16'sd1234; in_im = 16'sd567;
            cyc();
        end
        in_valid = 1'b0; in_sop = 1'b0;
        chk("mid_addra_pre", rom_addra, 32);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_sop",   out_sop,   0);
        chk("mid_rst_re",    $signed(out_re), 0);
        chk("mid_rst_im",    $signed(out_im), 0);
        chk("mid_rst_ovf",   ovf,       0);
        chk("mid_rst_addra", rom_addra, 0);
        chk("mid_rst_addrb", rom_addrb, 0);
        cyc();
        rst_n = 1'b1;
        for (int t = 0; t < 5; t++) begin
            cyc();
            chk($sformatf("mid_flush_valid_%0d", t), out_valid, 0);
        end
        for (int s = 0; s < 6; s++) begin
            in_valid = 1'b1; in_sop = 1'b0; in_re = 16'sd1000; in_im = 16'sd0;
            cyc();
            chk($sformatf("post_rst_addra_s%0d", s), rom_addra, ref_e(s) * 16);
        end
        in_valid = 1'b0;
        cyc();
        chk("post_rst_out_valid", out_valid, 1);
        chk("post_rst_out_re",    $signed(out_re), 1000);
        cyc(); cyc(); cyc(); cyc();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire
